// File: rtl/lsf_lut_rd_sched.sv
// lsf_lut_rd_sched: round-robin burst scheduler sharing one LUT ROM between N_REQ requesters.
// Optional LSF_LUT_ADDR_CLAMP_EN saturates burst addresses at the top of the ROM instead of wrapping.
module lsf_lut_rd_sched #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int ROM_LAT   = 2,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int IDX_W    = $clog2(BURST_LEN) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_rdy,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic [IDX_W-1:0]          rsp_idx,
  output logic                      rsp_last,
  output logic [DATA_W-1:0]         rsp_data,
`ifdef LSF_LUT_ADDR_CLAMP_EN
  output logic                      addr_clamped,
`endif
  output logic                      busy
);
  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic             v;
    logic [ID_W-1:0]  id;
    logic [IDX_W-1:0] idx;
    logic             last;
  } tag_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_id;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [IDX_W-1:0] k_q, k_d;
  tag_t sr_q [ROM_LAT];
  tag_t sr_d [ROM_LAT];
  tag_t tap;
  logic rsp_vld_q, rsp_vld_d, rsp_last_q, rsp_last_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic gnt_vld, beat_last, any_v;
`ifdef LSF_LUT_ADDR_CLAMP_EN
  logic [ADDR_W:0] sum;
  logic clamped_q, clamped_d;
`else
  logic [ADDR_W-1:0] sum;
`endif
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [ID_W-1:0] j;
    gnt_id = '0;
    j = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (req_vld[j]) gnt_id = j;
    end
    gnt_vld = |req_vld;
  end
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    start_d  = start_q;
    k_d      = k_q;
    if (state_q == IDLE) begin
      if (gnt_vld) begin
        state_d  = BURST;
        rr_ptr_d = gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
        id_d     = gnt_id;
        start_d  = req_addr[gnt_id*ADDR_W +: ADDR_W];
        k_d      = '0;
      end
    end else begin
      k_d     = k_q + 1'b1;
      state_d = beat_last ? IDLE : BURST;
    end
    sr_d[0] = {rom_en, id_q, k_q, beat_last};
    for (int i = 1; i < ROM_LAT; i++) sr_d[i] = sr_q[i-1];
    tap        = sr_q[ROM_LAT-1];
    rsp_vld_d  = tap.v;
    rsp_id_d   = tap.v ? tap.id : '0;
    rsp_idx_d  = tap.v ? tap.idx : '0;
    rsp_last_d = tap.v & tap.last;
    rsp_data_d = tap.v ? rom_data : '0;
`ifdef LSF_LUT_ADDR_CLAMP_EN
    clamped_d  = clamped_q | (rom_en & sum[ADDR_W]);
`endif
  end
  always_comb begin
    rom_en    = state_q == BURST;
    beat_last = k_q == IDX_W'(BURST_LEN - 1);
    req_rdy   = (state_q == IDLE && gnt_vld && !rst) ? N_REQ'(1) << gnt_id : '0;
`ifdef LSF_LUT_ADDR_CLAMP_EN
    sum          = {1'b0, start_q} + (ADDR_W+1)'(k_q);
    rom_addr     = rom_en ? (sum[ADDR_W] ? '1 : sum[ADDR_W-1:0]) : '0;
    addr_clamped = clamped_q | (rom_en & sum[ADDR_W]);
`else
    sum      = start_q + ADDR_W'(k_q);
    rom_addr = rom_en ? sum : '0;
`endif
    any_v = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) any_v = any_v | sr_q[i].v;
    busy     = rom_en | any_v | rsp_vld_q;
    rsp_vld  = rsp_vld_q;
    rsp_id   = rsp_id_q;
    rsp_idx  = rsp_idx_q;
    rsp_last = rsp_last_q;
    rsp_data = rsp_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      start_q    <= '0;
      k_q        <= '0;
      for (int i = 0; i < ROM_LAT; i++) sr_q[i] <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_idx_q  <= '0;
      rsp_last_q <= 1'b0;
      rsp_data_q <= '0;
`ifdef LSF_LUT_ADDR_CLAMP_EN
      clamped_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      start_q    <= start_d;
      k_q        <= k_d;
      for (int i = 0; i < ROM_LAT; i++) sr_q[i] <= sr_d[i];
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_last_q <= rsp_last_d;
      rsp_data_q <= rsp_data_d;
`ifdef LSF_LUT_ADDR_CLAMP_EN
      clamped_q  <= clamped_d;
`endif
    end
  end
endmodule

// File: doc/lsf_lut_rd_sched.md
Name: lsf_lut_rd_sched

Overview:
- Round-robin scheduler sharing one single-port LUT ROM between N_REQ segment-fit requesters.
- Each requester presents a LUT start address from its ROM-address stage. The block grants one requester at a time and issues a burst of BURST_LEN consecutive ROM reads from that start address.
- Returns the ROM words tagged with requester id, beat index and last flag.
- Sits between the per-requester address-calculation stages and the shared LUT ROM in the LSF pipeline.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 12, LUT address width.
- DATA_W, 16, ROM word width.
- BURST_LEN, 4, ROM reads per grant (1..16).
- ROM_LAT, 2, fixed ROM read latency in cycles, from rom_en to rom_data valid (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  N_REQ  per-requester request valid; held until accepted.
- req_addr  in  N_REQ*ADDR_W  per-requester start address; slice i belongs to requester i.
- req_rdy  out  N_REQ  one-hot accept pulse (combinational, valid in the grant cycle).
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en.
- rsp_vld  out  1  response word valid.
- rsp_id  out  $clog2(N_REQ)  requester id of the response.
- rsp_idx  out  $clog2(BURST_LEN)+1  beat index within the burst, 0-based.
- rsp_last  out  1  final beat of the burst.
- rsp_data  out  DATA_W  ROM word, registered.
- busy  out  1  high while in BURST state or while any read is in flight.

Behaviour:
- Reset value of all outputs is 0. Reset state is IDLE with round-robin pointer rr_ptr=0. In-flight pipeline valids are cleared.
- Reset asserted mid-burst aborts the burst; no rsp_vld is produced for reads issued before reset.
- FSM states: IDLE, BURST.
- IDLE with any req_vld bit set:
  - Grant the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Assert req_rdy[g] for that cycle only; req_rdy is 0 in every other cycle.
  - Latch req_addr slice g and id g; set beat counter k=0; set rr_ptr=(g+1) mod N_REQ.
  - Go to BURST.
- IDLE with no request: stay in IDLE; rr_ptr unchanged.
- BURST, each cycle:
  - rom_en=1, rom_addr=start+k (modulo 2^ADDR_W, i.e. wraps from 4095 to 0); increment k.
  - When k=BURST_LEN-1, go to IDLE.
- The cycle after the last beat is always an IDLE arbitration cycle, so there is exactly one bubble between back-to-back bursts.
- Burst timing: the first rom_en is the cycle after the grant; a burst occupies BURST_LEN+1 cycles, grant included.
- Response pipeline:
  - A ROM_LAT-deep shift register carries {valid, id, idx, last} alongside each read.
  - rsp_* are registered from rom_data and the shift-register tap. Total latency from rom_en to rsp_vld is ROM_LAT+1 cycles.
  - Responses appear in issue order and are never back-pressured.
- A requester deasserting req_vld before its grant is simply skipped.
- A requester that re-asserts req_vld in the cycle after its grant waits its full round-robin turn.
- req_addr is sampled only in the grant cycle; later changes do not affect the running burst.
- busy = (state==BURST) OR any shift-register valid OR rsp_vld.

Optional Feature:
- Macro: LSF_LUT_ADDR_CLAMP_EN.
- When defined: if start+k exceeds 2^ADDR_W-1, rom_addr saturates at 2^ADDR_W-1 instead of wrapping. A sticky output addr_clamped (1 bit, reset 0, cleared only by rst) sets on the first saturated beat. Beat count and rsp_idx are unchanged.
- When undefined: addresses wrap modulo 2^ADDR_W and the addr_clamped port does not exist.

Test Plan:
- Single request, req_vld[1]=1, req_addr[1]=0x100, defaults -> req_rdy[1] pulses in cycle 0; rom_addr=0x100..0x103 in cycles 1..4; rsp_vld in cycles 4..7 with rsp_id=1, rsp_idx=0..3, rsp_last only at idx 3.
- All three requesters held valid with rr_ptr=0 -> grant order 0,1,2,0; each burst 5 cycles apart including the 1-cycle bubble; req_rdy is always one-hot.
- Wrap: req_addr=0xFFE -> rom_addr=0xFFE, 0xFFF, 0x000, 0x001. With LSF_LUT_ADDR_CLAMP_EN defined: 0xFFE, 0xFFF, 0xFFF, 0xFFF, and addr_clamped=1 from the third beat.
- Reset asserted asynchronously at beat 2 of a burst -> all outputs 0 immediately; no rsp_vld afterwards; the next grant after reset release starts from requester 0.
- ROM_LAT=4, BURST_LEN=1, requester 2 only -> rsp_vld exactly 5 cycles after rom_en with rsp_last=1 and rsp_idx=0; busy high from the grant+1 cycle through the rsp_vld cycle.
- req_vld[0] dropped in the same cycle requester 1 is granted -> requester 0 is never granted; no spurious req_rdy[0].
